// File: rtl/jtvigil_sdram_pkg.sv
// Shared SDRAM-side definitions for the jtvigil ROM slots and the download logic.
package jtvigil_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LO   = 2'd2,
        HI   = 2'd3
    } slot_state_t;

endpackage

// File: rtl/jtvigil_romslot.sv
// Single-line (32-bit) read cache between a ROM client and a 16-bit SDRAM port.
// A miss fetches two halfwords (low then high) into the line; hits are answered combinationally.
module jtvigil_romslot
    import jtvigil_sdram_pkg::*;
#(
    parameter int          AW     = 18,
    parameter int          DW     = 8,
    parameter logic [21:0] OFFSET = 22'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_rd,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_din
);

    localparam int LW = (DW == 8) ? AW - 2 : AW;

    slot_state_t   state, state_next;
    logic [31:0]   line;
    logic [LW-1:0] tag, pend, line_addr;
    logic          valid, hit, start;

    generate
        if (DW == 8) begin : g_byte
            assign line_addr = addr[AW-1:2];
            assign data      = line[{addr[1:0], 3'b000} +: 8];
        end else if (DW == 32) begin : g_word
            assign line_addr = addr;
            assign data      = line;
        end else begin : g_bad
            $error("jtvigil_romslot: DW must be 8 or 32");
        end
    endgenerate

    assign hit = valid && (tag == line_addr);
    assign ok  = cs && hit && !downloading;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            IDLE: if (cs && !hit && !downloading) begin
                state_next = REQ;
                start      = 1'b1;
            end
            REQ:  if (sdram_ack) state_next = LO;
            LO:   if (sdram_dok) state_next = HI;
            HI:   if (sdram_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line       <= '0;
            tag        <= '0;
            pend       <= '0;
            valid      <= 1'b0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
        end else begin
            if (start) begin
                pend       <= line_addr;
                sdram_addr <= OFFSET + 22'({line_addr, 1'b0});
                sdram_rd   <= 1'b1;
            end
            if (state == REQ && sdram_ack) sdram_rd <= 1'b0;
            if (state == LO && sdram_dok) line[15:0]  <= sdram_din;
            if (state == HI && sdram_dok) line[31:16] <= sdram_din;
            if (state == HI && sdram_rdy) tag <= pend;
            // a burst finishing while a download runs must leave the line invalid
            if (downloading || start)         valid <= 1'b0;
            else if (state == HI && sdram_rdy) valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtvigil_romslot.sv
// Bench for jtvigil_romslot: a byte-wide and a word-wide slot sharing one SDRAM response bus.
module tb_jtvigil_romslot;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        ack = 1'b0, dok = 1'b0, rdy = 1'b0;
    logic [15:0] din = '0;

    logic        cs8 = 1'b0, ok8, rd8;
    logic [17:0] addr8 = '0;
    logic [7:0]  data8;
    logic [21:0] sa8;

    logic        cs32 = 1'b0, ok32, rd32;
    logic [17:0] addr32 = '0;
    logic [31:0] data32;
    logic [21:0] sa32;

    int checks = 0;
    int errors = 0;
    logic [7:0]  sb8[$];
    logic [31:0] sb32[$];

    always #5 clk = ~clk;

    jtvigil_romslot #(.AW(18), .DW(8), .OFFSET(22'h10000)) dut8 (
        .clk(clk), .rst(rst), .downloading(downloading), .cs(cs8), .addr(addr8),
        .data(data8), .ok(ok8), .sdram_addr(sa8), .sdram_rd(rd8), .sdram_ack(ack),
        .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din)
    );

    jtvigil_romslot #(.AW(18), .DW(32), .OFFSET(22'h100)) dut32 (
        .clk(clk), .rst(rst), .downloading(downloading), .cs(cs32), .addr(addr32),
        .data(data32), .ok(ok32), .sdram_addr(sa32), .sdram_rd(rd32), .sdram_ack(ack),
        .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din)
    );

    function automatic logic rd_of(input int sel);
        return (sel != 0) ? rd32 : rd8;
    endfunction

    // SDRAM responder: waits for a request, acks after ack_delay cycles, returns lo then hi+rdy.
    task automatic serve(input int sel, input int ack_delay, input logic [15:0] lo, input logic [15:0] hi,
                         output bit seen, output logic [21:0] a, output int rd_cycles,
                         output bit rd_dropped, output bit ok_early);
        int n = 0;
        seen = 0; a = '0; rd_cycles = 0; rd_dropped = 0; ok_early = 0;
        while (!rd_of(sel) && n < 20) begin @(negedge clk); n++; end
        if (!rd_of(sel)) return;
        seen = 1;
        a = (sel != 0) ? sa32 : sa8;
        rd_cycles = 1;
        repeat (ack_delay) begin @(negedge clk); if (rd_of(sel)) rd_cycles++; end
        ack = 1'b1; @(negedge clk);
        ack = 1'b0; rd_dropped = !rd_of(sel);
        dok = 1'b1; din = lo; @(negedge clk);
        din = hi; rdy = 1'b1; ok_early = (sel != 0) ? ok32 : ok8; @(negedge clk);
        dok = 1'b0; rdy = 1'b0; din = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs8 = 1'b1; addr8 = '0; cs32 = 1'b1; addr32 = '0;
        repeat (3) @(negedge clk);
        checks++; if (rd8 !== 1'b0) begin errors++; $display("FAIL reset_rd8: got %b want 0", rd8); end
        checks++; if (sa8 !== 22'h0) begin errors++; $display("FAIL reset_sa8: got %h want 0", sa8); end
        checks++; if (ok8 !== 1'b0) begin errors++; $display("FAIL reset_ok8: got %b want 0", ok8); end
        checks++; if (data8 !== 8'h0) begin errors++; $display("FAIL reset_data8: got %h want 0", data8); end
        checks++; if (rd32 !== 1'b0) begin errors++; $display("FAIL reset_rd32: got %b want 0", rd32); end
        checks++; if (ok32 !== 1'b0) begin errors++; $display("FAIL reset_ok32: got %b want 0", ok32); end
        checks++; if (data32 !== 32'h0) begin errors++; $display("FAIL reset_data32: got %h want 0", data32); end
        cs8 = 1'b0; cs32 = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_byte();
        bit seen, drop, early; logic [21:0] a; int rc; logic [7:0] exp;
        @(negedge clk);
        cs8 = 1'b1; addr8 = 18'h5; sb8.push_back(8'hBB);
        serve(0, 0, 16'hBBAA, 16'hDDCC, seen, a, rc, drop, early);
        checks++; if (!seen) begin errors++; $display("FAIL fill_rd_timeout: got no sdram_rd want request"); end
        checks++; if (a !== 22'h10002) begin errors++; $display("FAIL fill_sdram_addr: got %h want 010002", a); end
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL fill_rd_after_ack: got still high want low"); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL fill_ok_early: got 1 want 0 before rdy"); end
        checks++;
        if (ok8 !== 1'b1) begin errors++; $display("FAIL fill_ok: got %b want 1", ok8); end
        else if (sb8.size() == 0) begin errors++; $display("FAIL fill_sb: got empty queue want entry"); end
        else begin
            exp = sb8.pop_front();
            if (data8 !== exp) begin errors++; $display("FAIL fill_data: got %h want %h", data8, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ad[4] = '{18'h6, 18'h7, 18'h4, 18'h5};
        logic [7:0]  ev[4] = '{8'hCC, 8'hDD, 8'hAA, 8'hBB};
        logic [7:0]  exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (rd8 !== 1'b0) begin errors++; $display("FAIL b2b_rd[%0d]: got %b want 0", i, rd8); end
            addr8 = ad[i]; sb8.push_back(ev[i]);
            #1;
            checks++;
            if (ok8 !== 1'b1) begin errors++; $display("FAIL b2b_ok[%0d]: got %b want 1", i, ok8); end
            else if (sb8.size() == 0) begin errors++; $display("FAIL b2b_sb[%0d]: got empty want entry", i); end
            else begin
                exp = sb8.pop_front();
                if (data8 !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data8, exp); end
            end
        end
        @(negedge clk);
        checks++; if (rd8 !== 1'b0) begin errors++; $display("FAIL b2b_rd_end: got %b want 0", rd8); end
        cs8 = 1'b0;
    endtask

    task automatic test_addr_change();
        bit seen, drop, early; logic [21:0] a; int rc; int n = 0; logic [31:0] exp;
        @(negedge clk);
        cs32 = 1'b1; addr32 = 18'h5;
        while (!rd32 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rd32 !== 1'b1) begin errors++; $display("FAIL chg_rd_timeout: got %b want 1", rd32); end
        checks++; if (sa32 !== 22'h10A) begin errors++; $display("FAIL chg_sa1: got %h want 00010a", sa32); end
        ack = 1'b1; @(negedge clk);
        ack = 1'b0;
        checks++; if (rd32 !== 1'b0) begin errors++; $display("FAIL chg_rd_ack: got %b want 0", rd32); end
        dok = 1'b1; din = 16'h1111; addr32 = 18'h9; sb32.push_back(32'h4444_3333);
        @(negedge clk);
        din = 16'h2222; rdy = 1'b1;
        @(negedge clk);
        dok = 1'b0; rdy = 1'b0; din = '0;
        checks++; if (ok32 !== 1'b0) begin errors++; $display("FAIL chg_ok_miss: got %b want 0", ok32); end
        checks++; if (data32 !== 32'h2222_1111) begin errors++; $display("FAIL chg_line1: got %h want 22221111", data32); end
        checks++; if (rd32 !== 1'b0) begin errors++; $display("FAIL chg_rd_gap: got %b want 0", rd32); end
        @(negedge clk);
        checks++; if (rd32 !== 1'b1) begin errors++; $display("FAIL chg_rd_next: got %b want 1", rd32); end
        serve(1, 0, 16'h3333, 16'h4444, seen, a, rc, drop, early);
        checks++; if (a !== 22'h112) begin errors++; $display("FAIL chg_sa2: got %h want 000112", a); end
        checks++;
        if (ok32 !== 1'b1) begin errors++; $display("FAIL chg_ok: got %b want 1", ok32); end
        else if (sb32.size() == 0) begin errors++; $display("FAIL chg_sb: got empty want entry"); end
        else begin
            exp = sb32.pop_front();
            if (data32 !== exp) begin errors++; $display("FAIL chg_data: got %h want %h", data32, exp); end
        end
        cs32 = 1'b0;
    endtask

    task automatic test_ack_delay();
        bit seen, drop, early; logic [21:0] a; int rc; int rd_after = 0; logic [7:0] exp;
        @(negedge clk);
        cs8 = 1'b1; addr8 = 18'h100; sb8.push_back(8'h34);
        serve(0, 7, 16'h1234, 16'h5678, seen, a, rc, drop, early);
        checks++; if (a !== 22'h10080) begin errors++; $display("FAIL dly_sa: got %h want 010080", a); end
        checks++; if (rc != 8) begin errors++; $display("FAIL dly_rd_cycles: got %0d want 8", rc); end
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL dly_rd_drop: got still high want low"); end
        checks++;
        if (ok8 !== 1'b1) begin errors++; $display("FAIL dly_ok: got %b want 1", ok8); end
        else if (sb8.size() == 0) begin errors++; $display("FAIL dly_sb: got empty want entry"); end
        else begin
            exp = sb8.pop_front();
            if (data8 !== exp) begin errors++; $display("FAIL dly_data: got %h want %h", data8, exp); end
        end
        repeat (5) begin @(negedge clk); if (rd8) rd_after++; end
        checks++; if (rd_after != 0) begin errors++; $display("FAIL dly_extra_rd: got %0d cycles want 0", rd_after); end
        cs8 = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bit seen, drop, early; logic [21:0] a; int rc; int n = 0; logic [7:0] exp;
        @(negedge clk);
        cs8 = 1'b1; addr8 = 18'h200;
        while (!rd8 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rd8 !== 1'b1) begin errors++; $display("FAIL rstb_rd_timeout: got %b want 1", rd8); end
        ack = 1'b1; @(negedge clk);
        ack = 1'b0; dok = 1'b1; din = 16'h9999; @(negedge clk);
        rst = 1'b1; cs8 = 1'b0; dok = 1'b0; @(negedge clk);
        rst = 1'b0; dok = 1'b1; rdy = 1'b1; din = 16'hEEEE;
        repeat (2) @(negedge clk);
        dok = 1'b0; rdy = 1'b0; din = '0;
        @(negedge clk);
        checks++; if (rd8 !== 1'b0) begin errors++; $display("FAIL rstb_rd: got %b want 0", rd8); end
        cs8 = 1'b1; #1;
        checks++; if (ok8 !== 1'b0) begin errors++; $display("FAIL rstb_ok: got %b want 0", ok8); end
        checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL rstb_data: got %h want 00", data8); end
        sb8.push_back(8'h0B);
        serve(0, 0, 16'h0A0B, 16'h0C0D, seen, a, rc, drop, early);
        checks++; if (!seen || a !== 22'h10100) begin errors++; $display("FAIL rstb_refill: got seen=%0b addr=%h want 1 010100", seen, a); end
        checks++;
        if (ok8 !== 1'b1) begin errors++; $display("FAIL rstb_ok2: got %b want 1", ok8); end
        else if (sb8.size() == 0) begin errors++; $display("FAIL rstb_sb: got empty want entry"); end
        else begin
            exp = sb8.pop_front();
            if (data8 !== exp) begin errors++; $display("FAIL rstb_data2: got %h want %h", data8, exp); end
        end
        cs8 = 1'b0;
    endtask

    task automatic test_download();
        bit seen, drop, early; logic [21:0] a; int rc; int ok_hi = 0; int rd_hi = 0; logic [7:0] exp;
        @(negedge clk);
        downloading = 1'b1; cs8 = 1'b1; addr8 = 18'h200;
        repeat (20) begin
            #1; if (ok8) ok_hi++;
            @(negedge clk); if (rd8) rd_hi++;
        end
        checks++; if (ok_hi != 0) begin errors++; $display("FAIL dl_ok: got %0d cycles high want 0", ok_hi); end
        checks++; if (rd_hi != 0) begin errors++; $display("FAIL dl_rd: got %0d cycles high want 0", rd_hi); end
        downloading = 1'b0; sb8.push_back(8'h5A);
        serve(0, 0, 16'hA55A, 16'h0FF0, seen, a, rc, drop, early);
        checks++; if (!seen || a !== 22'h10100) begin errors++; $display("FAIL dl_refill: got seen=%0b addr=%h want 1 010100", seen, a); end
        checks++;
        if (ok8 !== 1'b1) begin errors++; $display("FAIL dl_ok2: got %b want 1", ok8); end
        else if (sb8.size() == 0) begin errors++; $display("FAIL dl_sb: got empty want entry"); end
        else begin
            exp = sb8.pop_front();
            if (data8 !== exp) begin errors++; $display("FAIL dl_data: got %h want %h", data8, exp); end
        end
        cs8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_byte();
        test_back_to_back();
        test_addr_change();
        test_ack_delay();
        test_reset_mid_burst();
        test_download();
        checks++;
        if (sb8.size() != 0 || sb32.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d/%0d pending want 0/0", sb8.size(), sb32.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
